// File: rtl/div_clk_monitor_if.sv
// Bundle of the monitor's control input, divided clock under test and measurement results.
interface div_clk_monitor_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             en;
    logic             div_clk;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             ratio_pow2;
    logic             mismatch;
    logic             stall;

    // Source side: drives enable and the divided clock, consumes the results.
    modport master (
        output en, div_clk,
        input  period, high_time, meas_valid, locked, ratio_pow2, mismatch, stall
    );

    // Monitor side.
    modport slave (
        input  en, div_clk,
        output period, high_time, meas_valid, locked, ratio_pow2, mismatch, stall
    );
endinterface

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock sampled in its source clock domain,
// tracks ratio lock, and flags ratio changes and a stuck divided clock.
module div_clk_monitor #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOCK_N = 2
) (
    input logic              clk_in,
    input logic              rst,
    div_clk_monitor_if.slave bus
);
    typedef enum logic {StIdle, StMeas} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [4:0]       LOCK_TGT = 5'(LOCK_N);

    state_t           state_q, state_d;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [3:0]       match_q, match_d;
    logic             first_q, first_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             meas_valid_q, meas_valid_d;
    logic             mismatch_q, mismatch_d;
    logic             locked_q, locked_d;
    logic             stall_q, stall_d;
    logic             pow2_q, pow2_d;
    logic             rise;

    assign rise = bus.div_clk & ~div_q;

    // Next-state: measurement counters, lock tracking and stall detection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        match_d      = match_q;
        first_d      = first_q;
        period_d     = period_q;
        high_d       = high_q;
        meas_valid_d = 1'b0;
        mismatch_d   = 1'b0;
        locked_d     = locked_q;
        stall_d      = stall_q;

        if (!bus.en) begin
            // Soft clear: results are kept, everything else restarts.
            state_d  = StIdle;
            cnt_d    = '0;
            hi_d     = '0;
            match_d  = '0;
            first_d  = 1'b0;
            locked_d = 1'b0;
            stall_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    hi_d  = '0;
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        hi_d    = CNT_ONE;
                        first_d = 1'b1;
                        state_d = StMeas;
                    end
                end
                StMeas: begin
                    if (rise) begin
                        period_d     = cnt_q;
                        high_d       = hi_q;
                        meas_valid_d = 1'b1;
                        cnt_d        = CNT_ONE;
                        hi_d         = CNT_ONE;
                        first_d      = 1'b0;
                        // The first measurement after arming has nothing to compare against.
                        if (!first_q) begin
                            if (period_q == cnt_q && high_q == hi_q) begin
                                if ({1'b0, match_q} < LOCK_TGT) match_d = match_q + 4'd1;
                                if ({1'b0, match_q} + 5'd1 >= LOCK_TGT) locked_d = 1'b1;
                            end else begin
                                mismatch_d = 1'b1;
                                locked_d   = 1'b0;
                                match_d    = '0;
                            end
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        stall_d  = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                        cnt_d    = '0;
                        hi_d     = '0;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (bus.div_clk) hi_d = hi_q + CNT_ONE;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Evaluated on the updated lock/period so it tracks them in the same cycle.
        pow2_d = locked_d && (period_d >= CNT_TWO) && ((period_d & (period_d - CNT_ONE)) == '0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= StIdle;
            div_q        <= 1'b0;
            cnt_q        <= '0;
            hi_q         <= '0;
            match_q      <= '0;
            first_q      <= 1'b0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            mismatch_q   <= 1'b0;
            locked_q     <= 1'b0;
            stall_q      <= 1'b0;
            pow2_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= bus.div_clk;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            match_q      <= match_d;
            first_q      <= first_d;
            period_q     <= period_d;
            high_q       <= high_d;
            meas_valid_q <= meas_valid_d;
            mismatch_q   <= mismatch_d;
            locked_q     <= locked_d;
            stall_q      <= stall_d;
            pow2_q       <= pow2_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.locked     = locked_q;
    assign bus.stall      = stall_q;
    assign bus.ratio_pow2 = pow2_q;
endmodule
